// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants, instruction field positions and ID-stage types.
// Imported by the ID stage top and its hazard unit.
package id_stage_pipe_pkg;

  localparam int unsigned WORD_W   = 32;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_MSB   = 25;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_MSB   = 20;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned TGT_MSB  = 25;
  localparam int unsigned FUNC_MSB = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_RF,
    FWD_M,
    FWD_W
  } fwd_sel_e;

  typedef struct packed {
    logic              vld;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } ifid_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational load-use / branch-operand stall detection and operand forward select.
// Zero latency; the stall output is the backpressure the ID stage presents to IF.
module id_hazard_unit
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  valid_i,
  input  logic [5:0]            op_i,
  input  logic [5:0]            func_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic                  ex_regwe_i,
  input  logic                  ex_memrd_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic                  m_regwe_i,
  input  logic                  m_memrd_i,
  input  logic [REG_ADDR_W-1:0] m_waddr_i,
  input  logic                  w_regwe_i,
  input  logic [REG_ADDR_W-1:0] w_waddr_i,
  output logic                  stall_o,
  output fwd_sel_e              fwd1_o,
  output fwd_sel_e              fwd2_o
);

  logic use_rs, use_rt, is_br, is_jr, cmp_rs, cmp_rt, rs_nz, rt_nz;
  logic ld_use, ex_cmp, m_cmp;

  // A load result in M is not yet available, so M forwarding skips loads.
  function automatic fwd_sel_e pick(input logic [REG_ADDR_W-1:0] a);
    if (a == '0)                                         return FWD_ZERO;
    else if (m_regwe_i && !m_memrd_i && (m_waddr_i == a)) return FWD_M;
    else if (w_regwe_i && (w_waddr_i == a))              return FWD_W;
    else                                                 return FWD_RF;
  endfunction

  always_comb begin
    use_rs = !(op_i inside {OP_J, OP_JAL, OP_LUI});
    use_rt = op_i inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    is_br  = (op_i == OP_BEQ) || (op_i == OP_BNE);
    is_jr  = (op_i == OP_RTYPE) && (func_i == FUNC_JR);
    cmp_rs = is_br || is_jr;
    cmp_rt = is_br;
    rs_nz  = (rs_i != '0);
    rt_nz  = (rt_i != '0);

    ld_use = ex_memrd_i && ex_regwe_i &&
             ((use_rs && rs_nz && (ex_waddr_i == rs_i)) ||
              (use_rt && rt_nz && (ex_waddr_i == rt_i)));
    ex_cmp = ex_regwe_i &&
             ((cmp_rs && rs_nz && (ex_waddr_i == rs_i)) ||
              (cmp_rt && rt_nz && (ex_waddr_i == rt_i)));
    m_cmp  = m_memrd_i &&
             ((cmp_rs && rs_nz && (m_waddr_i == rs_i)) ||
              (cmp_rt && rt_nz && (m_waddr_i == rt_i)));

    stall_o = valid_i && (ld_use || ex_cmp || m_cmp);
    fwd1_o  = pick(rs_i);
    fwd2_o  = pick(rt_i);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: IF/ID register, hazard stalls, M/W forwarding, branch/jump resolution.
// One cycle IF->EX latency; id_ready_o drops while a hazard holds the IF/ID register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter bit          DELAY_SLOT  = 1'b1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid_i,
  input  logic [31:0]            if_instr_i,
  input  logic [31:0]            if_pc_i,
  output logic                   id_ready_o,
  input  logic                   flush_i,
  output logic [REG_ADDR_W-1:0]  rf_raddr1_o,
  output logic [REG_ADDR_W-1:0]  rf_raddr2_o,
  input  logic [31:0]            rf_rdata1_i,
  input  logic [31:0]            rf_rdata2_i,
  input  logic                   ex_regwe_i,
  input  logic                   ex_memrd_i,
  input  logic [REG_ADDR_W-1:0]  ex_waddr_i,
  input  logic                   m_regwe_i,
  input  logic                   m_memrd_i,
  input  logic [REG_ADDR_W-1:0]  m_waddr_i,
  input  logic [31:0]            m_data_i,
  input  logic                   w_regwe_i,
  input  logic [REG_ADDR_W-1:0]  w_waddr_i,
  input  logic [31:0]            w_data_i,
  output logic                   id_valid_o,
  output logic [31:0]            id_instr_o,
  output logic [31:0]            id_pc_o,
  output logic [31:0]            id_op1_o,
  output logic [31:0]            id_op2_o,
  output logic                   redirect_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   link_pc_o_unused_guard,
  output logic [31:0]            link_pc_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  ifid_t                  ifid_q, ifid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]            op, func;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic                  stall, take, live;
  logic                  is_beq, is_bne, is_j, is_jal, is_jr;
  fwd_sel_e              fwd1, fwd2;
  logic [31:0]           pc_plus4, br_target, j_target;

  assign op   = ifid_q.instr[OP_MSB:OP_LSB];
  assign func = ifid_q.instr[FUNC_MSB:0];
  assign rs   = REG_ADDR_W'(ifid_q.instr[RS_MSB:RS_LSB]);
  assign rt   = REG_ADDR_W'(ifid_q.instr[RT_MSB:RT_LSB]);

  id_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .valid_i    (ifid_q.vld),
    .op_i       (op),
    .func_i     (func),
    .rs_i       (rs),
    .rt_i       (rt),
    .ex_regwe_i (ex_regwe_i),
    .ex_memrd_i (ex_memrd_i),
    .ex_waddr_i (ex_waddr_i),
    .m_regwe_i  (m_regwe_i),
    .m_memrd_i  (m_memrd_i),
    .m_waddr_i  (m_waddr_i),
    .w_regwe_i  (w_regwe_i),
    .w_waddr_i  (w_waddr_i),
    .stall_o    (stall),
    .fwd1_o     (fwd1),
    .fwd2_o     (fwd2)
  );

  always_comb begin
    unique case (fwd1)
      FWD_ZERO: id_op1_o = ZERO_WORD;
      FWD_M:    id_op1_o = m_data_i;
      FWD_W:    id_op1_o = w_data_i;
      default:  id_op1_o = rf_rdata1_i;
    endcase
    unique case (fwd2)
      FWD_ZERO: id_op2_o = ZERO_WORD;
      FWD_M:    id_op2_o = m_data_i;
      FWD_W:    id_op2_o = w_data_i;
      default:  id_op2_o = rf_rdata2_i;
    endcase
  end

  always_comb begin
    is_beq    = (op == OP_BEQ);
    is_bne    = (op == OP_BNE);
    is_j      = (op == OP_J);
    is_jal    = (op == OP_JAL);
    is_jr     = (op == OP_RTYPE) && (func == FUNC_JR);
    take      = (is_beq && (id_op1_o == id_op2_o)) || (is_bne && (id_op1_o != id_op2_o)) ||
                is_j || is_jal || is_jr;
    live      = ifid_q.vld && !stall;
    pc_plus4  = ifid_q.pc + 32'd4;
    br_target = pc_plus4 + {{14{ifid_q.instr[IMM_MSB]}}, ifid_q.instr[IMM_MSB:0], 2'b00};
    j_target  = {pc_plus4[31:28], ifid_q.instr[TGT_MSB:0], 2'b00};
    if (is_jr)                redirect_pc_o = id_op1_o;
    else if (is_j || is_jal)  redirect_pc_o = j_target;
    else                      redirect_pc_o = br_target;
  end

  assign redirect_o  = live && take;
  assign id_ready_o  = !stall;
  // The all-zero word is a NOP: it travels through IF/ID but is never offered to EX.
  assign id_valid_o  = live && (ifid_q.instr != ZERO_WORD);
  assign id_instr_o  = ifid_q.instr;
  assign id_pc_o     = ifid_q.pc;
  assign link_pc_o   = ifid_q.pc + (DELAY_SLOT ? 32'd8 : 32'd4);
  assign link_pc_o_unused_guard = 1'b0;
  assign rf_raddr1_o = rs;
  assign rf_raddr2_o = rt;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.vld   = 1'b0;
      ifid_d.instr = ZERO_WORD;
    end else if (!stall) begin
      if (redirect_o && !DELAY_SLOT) begin
        ifid_d.vld   = 1'b0;
        ifid_d.instr = ZERO_WORD;
      end else begin
        ifid_d = '{vld: if_valid_i, instr: if_instr_i, pc: if_pc_i};
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ifid_q      <= ifid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (delay slot with 16-bit counter, squash with 2-bit
// counter) share directed stimulus and are checked every cycle against a behavioural model.
module tb_id_stage_pipe;

  localparam logic [31:0] ADD_3_2_4 = 32'h0044_1820;
  localparam logic [31:0] ADD_6_5_0 = 32'h00A0_3020;
  localparam logic [31:0] ADD_6_0_0 = 32'h0000_3020;
  localparam logic [31:0] BEQ_1_1   = 32'h1021_0004;
  localparam logic [31:0] JR_31     = 32'h03E0_0008;
  localparam logic [31:0] JAL_100   = 32'h0C00_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_i, flush_i;
  logic [31:0] if_instr_i, if_pc_i;
  logic        ex_regwe_i, ex_memrd_i, m_regwe_i, m_memrd_i, w_regwe_i;
  logic [4:0]  ex_waddr_i, m_waddr_i, w_waddr_i;
  logic [31:0] m_data_i, w_data_i;
  logic [31:0] rf [32];

  logic        a_ready, a_valid, a_red, a_guard;
  logic [4:0]  a_ra1, a_ra2;
  logic [31:0] a_rd1, a_rd2, a_instr, a_pc, a_op1, a_op2, a_rpc, a_lpc;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_red, b_guard;
  logic [4:0]  b_ra1, b_ra2;
  logic [31:0] b_rd1, b_rd2, b_instr, b_pc, b_op1, b_op2, b_rpc, b_lpc;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign a_rd1 = rf[a_ra1];
  assign a_rd2 = rf[a_ra2];
  assign b_rd1 = rf[b_ra1];
  assign b_rd2 = rf[b_ra2];

  id_stage_pipe #(.REG_ADDR_W(5), .DELAY_SLOT(1'b1), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_ready_o(a_ready), .flush_i(flush_i), .rf_raddr1_o(a_ra1), .rf_raddr2_o(a_ra2),
    .rf_rdata1_i(a_rd1), .rf_rdata2_i(a_rd2), .ex_regwe_i(ex_regwe_i), .ex_memrd_i(ex_memrd_i),
    .ex_waddr_i(ex_waddr_i), .m_regwe_i(m_regwe_i), .m_memrd_i(m_memrd_i), .m_waddr_i(m_waddr_i),
    .m_data_i(m_data_i), .w_regwe_i(w_regwe_i), .w_waddr_i(w_waddr_i), .w_data_i(w_data_i),
    .id_valid_o(a_valid), .id_instr_o(a_instr), .id_pc_o(a_pc), .id_op1_o(a_op1), .id_op2_o(a_op2),
    .redirect_o(a_red), .redirect_pc_o(a_rpc), .link_pc_o_unused_guard(a_guard),
    .link_pc_o(a_lpc), .stall_cnt_o(a_cnt)
  );

  id_stage_pipe #(.REG_ADDR_W(5), .DELAY_SLOT(1'b0), .STALL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_ready_o(b_ready), .flush_i(flush_i), .rf_raddr1_o(b_ra1), .rf_raddr2_o(b_ra2),
    .rf_rdata1_i(b_rd1), .rf_rdata2_i(b_rd2), .ex_regwe_i(ex_regwe_i), .ex_memrd_i(ex_memrd_i),
    .ex_waddr_i(ex_waddr_i), .m_regwe_i(m_regwe_i), .m_memrd_i(m_memrd_i), .m_waddr_i(m_waddr_i),
    .m_data_i(m_data_i), .w_regwe_i(w_regwe_i), .w_waddr_i(w_waddr_i), .w_data_i(w_data_i),
    .id_valid_o(b_valid), .id_instr_o(b_instr), .id_pc_o(b_pc), .id_op1_o(b_op1), .id_op2_o(b_op2),
    .redirect_o(b_red), .redirect_pc_o(b_rpc), .link_pc_o_unused_guard(b_guard),
    .link_pc_o(b_lpc), .stall_cnt_o(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model state, index 1 = delay-slot instance, index 0 = squash instance.
  bit          mv [2] = '{0, 0};
  logic [31:0] mi [2] = '{0, 0};
  logic [31:0] mp [2] = '{0, 0};
  int          mc [2] = '{0, 0};

  typedef struct packed {
    bit          st;
    bit          red;
    bit          urs;
    bit          urt;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] tgt;
  } exp_t;

  function automatic logic [31:0] fwd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_regwe_i && !m_memrd_i && m_waddr_i == a) return m_data_i;
    if (w_regwe_i && w_waddr_i == a) return w_data_i;
    return rf[a];
  endfunction

  function automatic exp_t eval(input bit v, input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit br, jr, ha, hb, hc;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    e.urs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
    e.urt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
    br = (op == 6'h04 || op == 6'h05);
    jr = (op == 6'h00 && fn == 6'h08);
    ha = ex_memrd_i && ex_regwe_i && ((e.urs && rs != 0 && rs == ex_waddr_i) ||
                                      (e.urt && rt != 0 && rt == ex_waddr_i));
    hb = (br || jr) && ex_regwe_i && ((rs != 0 && rs == ex_waddr_i) || (br && rt != 0 && rt == ex_waddr_i));
    hc = (br || jr) && m_memrd_i && ((rs != 0 && rs == m_waddr_i) || (br && rt != 0 && rt == m_waddr_i));
    e.st  = v && (ha || hb || hc);
    e.v1  = fwd(rs);
    e.v2  = fwd(rt);
    e.red = v && !e.st && ((op == 6'h04 && e.v1 == e.v2) || (op == 6'h05 && e.v1 != e.v2) ||
                           op == 6'h02 || op == 6'h03 || jr);
    if (jr) e.tgt = e.v1;
    else if (op == 6'h02 || op == 6'h03) e.tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) << 2);
    else e.tgt = pc + 32'd4 + (32'($signed(ins[15:0])) << 2);
    return e;
  endfunction

  exp_t me;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] <= 1'b0; mi[k] <= 32'd0; mp[k] <= 32'd0; mc[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        me = eval(mv[k], mi[k], mp[k]);
        if (flush_i) begin
          mv[k] <= 1'b0; mi[k] <= 32'd0;
        end else if (!me.st) begin
          if (me.red && k == 0) begin
            mv[k] <= 1'b0; mi[k] <= 32'd0;
          end else begin
            mv[k] <= if_valid_i; mi[k] <= if_instr_i; mp[k] <= if_pc_i;
          end
        end
        if (me.st && mc[k] < ((k == 1) ? 65535 : 3)) mc[k] <= mc[k] + 1;
      end
    end
  end

  task automatic cmp(input int k, input logic rdy, input logic vld, input logic red,
                     input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] o1,
                     input logic [31:0] o2, input logic [31:0] rpc, input logic [31:0] lpc,
                     input logic [31:0] cnt, input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    bit   ev;
    e  = eval(mv[k], mi[k], mp[k]);
    ev = mv[k] && !e.st && (mi[k] != 32'd0);
    chk($sformatf("dut%0d ready", k), 32'(rdy), 32'(!e.st));
    chk($sformatf("dut%0d valid", k), 32'(vld), 32'(ev));
    chk($sformatf("dut%0d redirect", k), 32'(red), 32'(e.red));
    chk($sformatf("dut%0d stall_cnt", k), cnt, 32'(mc[k]));
    chk($sformatf("dut%0d raddr1", k), 32'(ra1), 32'(mi[k][25:21]));
    chk($sformatf("dut%0d raddr2", k), 32'(ra2), 32'(mi[k][20:16]));
    if (ev) begin
      chk($sformatf("dut%0d instr", k), ins, mi[k]);
      chk($sformatf("dut%0d pc", k), pc, mp[k]);
      chk($sformatf("dut%0d link", k), lpc, mp[k] + ((k == 1) ? 32'd8 : 32'd4));
      if (e.urs) chk($sformatf("dut%0d op1", k), o1, e.v1);
      if (e.urt) chk($sformatf("dut%0d op2", k), o2, e.v2);
    end
    if (e.red) chk($sformatf("dut%0d redirect_pc", k), rpc, e.tgt);
  endtask

  always @(negedge clk) begin
    cmp(1, a_ready, a_valid, a_red, a_instr, a_pc, a_op1, a_op2, a_rpc, a_lpc, 32'(a_cnt), a_ra1, a_ra2);
    cmp(0, b_ready, b_valid, b_red, b_instr, b_pc, b_op1, b_op2, b_rpc, b_lpc, 32'(b_cnt), b_ra1, b_ra2);
  end

  task automatic clr();
    ex_regwe_i = 0; ex_memrd_i = 0; ex_waddr_i = 0;
    m_regwe_i = 0; m_memrd_i = 0; m_waddr_i = 0; m_data_i = 0;
    w_regwe_i = 0; w_waddr_i = 0; w_data_i = 0; flush_i = 0;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    if_valid_i = 1'b1; if_instr_i = ins; if_pc_i = pc;
  endtask

  task automatic ex_load2();
    ex_memrd_i = 1; ex_regwe_i = 1; ex_waddr_i = 5'd2;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = 32'hDEAD_BEEF;
    clr(); if_valid_i = 0; if_instr_i = 0; if_pc_i = 0;

    @(negedge clk);
    chk("reset valid", 32'(a_valid), 32'd0);
    chk("reset redirect", 32'(a_red), 32'd0);
    chk("reset ready", 32'(a_ready), 32'd1);
    chk("reset cnt", 32'(a_cnt), 32'd0);

    // Three stall cycles, then reset lands mid-stall.
    nxt(); rst = 0; fetch(ADD_3_2_4, 32'h10);
    nxt(); ex_load2(); fetch(ADD_6_5_0, 32'h14);
    repeat (3) nxt();
    @(negedge clk);
    chk("mid-stall cnt", 32'(a_cnt), 32'd3);
    chk("mid-stall ready", 32'(a_ready), 32'd0);
    #2 rst = 1;
    #1;
    chk("async rst valid", 32'(a_valid), 32'd0);
    chk("async rst redirect", 32'(a_red), 32'd0);
    chk("async rst ready", 32'(a_ready), 32'd1);
    chk("async rst cnt", 32'(a_cnt), 32'd0);
    chk("async rst cnt2", 32'(b_cnt), 32'd0);
    #1 rst = 0; clr(); fetch(ADD_3_2_4, 32'h10);
    nxt(); fetch(ADD_3_2_4, 32'h14);
    @(negedge clk);
    chk("first add valid", 32'(a_valid), 32'd1);
    chk("first add pc", a_pc, 32'h10);

    // Load-use on $2.
    nxt(); ex_load2(); fetch(ADD_6_5_0, 32'h18);
    @(negedge clk);
    chk("load-use ready", 32'(a_ready), 32'd0);
    chk("load-use valid", 32'(a_valid), 32'd0);
    nxt(); m_memrd_i = 1; m_regwe_i = 1; m_waddr_i = 5'd2;
    @(negedge clk);
    chk("load-use cnt", 32'(a_cnt), 32'd1);
    chk("load-use 2nd stall", 32'(a_ready), 32'd0);
    nxt(); clr(); w_regwe_i = 1; w_waddr_i = 5'd2; w_data_i = 32'h55;
    @(negedge clk);
    chk("load-use op1 from W", a_op1, 32'h55);
    chk("load-use released", 32'(a_valid), 32'd1);

    // Forwarding priority M over W, and $0.
    nxt(); m_regwe_i = 1; m_waddr_i = 5'd5; m_data_i = 32'h11;
    w_regwe_i = 1; w_waddr_i = 5'd5; w_data_i = 32'h22; fetch(ADD_6_0_0, 32'h1C);
    @(negedge clk);
    chk("fwd M over W", a_op1, 32'h11);
    nxt(); m_waddr_i = 5'd0; w_waddr_i = 5'd0; fetch(BEQ_1_1, 32'h100);
    @(negedge clk);
    chk("fwd reg0", a_op1, 32'h0);

    // beq taken, delay slot vs squash.
    nxt(); clr(); fetch(ADD_3_2_4, 32'h104);
    @(negedge clk);
    chk("beq redirect", 32'(a_red), 32'd1);
    chk("beq target", a_rpc, 32'h114);
    chk("beq target ds0", b_rpc, 32'h114);
    nxt(); fetch(JR_31, 32'h300);
    @(negedge clk);
    chk("delay slot valid", 32'(a_valid), 32'd1);
    chk("delay slot pc", a_pc, 32'h104);
    chk("squashed slot", 32'(b_valid), 32'd0);

    // jr with EX writer of $31, then M forwarding.
    nxt(); ex_regwe_i = 1; ex_waddr_i = 5'd31; fetch(ADD_3_2_4, 32'h304);
    @(negedge clk);
    chk("jr stall", 32'(a_ready), 32'd0);
    nxt(); clr(); m_regwe_i = 1; m_waddr_i = 5'd31; m_data_i = 32'h400;
    @(negedge clk);
    chk("jr redirect", 32'(a_red), 32'd1);
    chk("jr target", a_rpc, 32'h400);
    nxt(); clr(); fetch(JAL_100, 32'h200);
    nxt(); if_valid_i = 0; if_instr_i = 0;
    @(negedge clk);
    chk("jal link ds1", a_lpc, 32'h208);
    chk("jal link ds0", b_lpc, 32'h204);
    chk("jal target", a_rpc, 32'h400);

    // Flush overriding a stall.
    nxt(); fetch(ADD_3_2_4, 32'h20);
    nxt(); ex_load2(); flush_i = 1; if_valid_i = 0;
    @(negedge clk);
    chk("flush+stall ready", 32'(a_ready), 32'd0);
    nxt(); flush_i = 0;
    @(negedge clk);
    chk("flushed bubble", 32'(a_valid), 32'd0);
    chk("flushed ready", 32'(a_ready), 32'd1);

    // Saturation of the 2-bit counter after five stall cycles.
    #2 rst = 1;
    #2 rst = 0; clr(); fetch(ADD_3_2_4, 32'h40);
    nxt(); ex_load2(); if_valid_i = 0;
    repeat (5) nxt();
    clr();
    @(negedge clk);
    chk("sat cnt2", 32'(b_cnt), 32'd3);
    chk("cnt16 after 5", 32'(a_cnt), 32'd5);
    repeat (3) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
